// File: rtl/ascii_num_formatter.sv
// ascii_num_formatter
//
// Formats a stream of signed two's-complement integers as space-separated
// ASCII decimal text. The last number of a frame is followed by a newline
// instead of a space. Each number is converted by repeated subtraction of
// powers of ten, most significant digit first, and leading zeros are
// suppressed.
//
// Optional feature (compile-time macro ASCII_FMT_CRLF_EN):
//   defined     -> the frame terminator is CR (0x0D) followed by LF (0x0A)
//   not defined -> the frame terminator is LF (0x0A) only
//
// Parameters
//   DATA_WIDTH     input integer width: 8, 16 or 32
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   clear          synchronous abort; back to idle, partial frame dropped
//   num_data       signed integer to format
//   num_valid      num_data valid
//   num_last       num_data is the final number of the frame
//   num_ready      formatter can accept a number (idle)
//   payload_data   ASCII character
//   payload_valid  payload_data valid
//   payload_last   final character of the frame (the LF)
//   payload_ready  downstream accepts the character
//   busy           formatter is not idle
//   frame_done     one-cycle pulse after the final character handshake
//   frame_len      byte count of the last completed frame

module ascii_num_formatter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] num_data,
  input  logic                         num_valid,
  input  logic                         num_last,
  output logic                         num_ready,
  output logic        [7:0]            payload_data,
  output logic                         payload_valid,
  output logic                         payload_last,
  input  logic                         payload_ready,
  output logic                         busy,
  output logic                         frame_done,
  output logic        [15:0]           frame_len
);

  localparam int MAX_DIGITS = (DATA_WIDTH == 8)  ? 3 :
                              (DATA_WIDTH == 16) ? 5 : 10;
  localparam int K_W = $clog2(MAX_DIGITS);
  localparam logic [K_W-1:0] K_TOP = K_W'(MAX_DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIGN,
    S_DIV,
    S_EMIT,
`ifdef ASCII_FMT_CRLF_EN
    S_CR,
`endif
    S_SEP
  } state_t;

  // 10^idx at the datapath width; only idx < MAX_DIGITS is ever used.
  function automatic logic [DATA_WIDTH-1:0] pow10(input logic [K_W-1:0] idx);
    case (32'(idx))
      0:       return DATA_WIDTH'(32'd1);
      1:       return DATA_WIDTH'(32'd10);
      2:       return DATA_WIDTH'(32'd100);
      3:       return DATA_WIDTH'(32'd1000);
      4:       return DATA_WIDTH'(32'd10000);
      5:       return DATA_WIDTH'(32'd100000);
      6:       return DATA_WIDTH'(32'd1000000);
      7:       return DATA_WIDTH'(32'd10000000);
      8:       return DATA_WIDTH'(32'd100000000);
      9:       return DATA_WIDTH'(32'd1000000000);
      default: return '0;
    endcase
  endfunction

  // Absolute value as unsigned. The most negative input negates to itself,
  // which read as unsigned is exactly 2^(DATA_WIDTH-1), so no overflow.
  function automatic logic [DATA_WIDTH-1:0] magnitude(
    input logic signed [DATA_WIDTH-1:0] v
  );
    logic [DATA_WIDTH-1:0] u;
    u = v;
    return u[DATA_WIDTH-1] ? (~u + DATA_WIDTH'(1)) : u;
  endfunction

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mag;
  logic [K_W-1:0]        k;
  logic [3:0]            cnt;
  logic                  started;
  logic                  last_f;
  logic [15:0]           byte_cnt;

  logic [DATA_WIDTH-1:0] pow_k;
  logic                  mag_ge;
  logic                  emit_now;
  logic                  num_acc;
  logic                  pay_hs;
  logic                  pay_final;

  assign pow_k    = pow10(k);
  assign mag_ge   = (mag >= pow_k);
  // A digit is emitted once the current power no longer fits, unless it is
  // a leading zero. The units digit is always emitted so zero prints "0".
  assign emit_now = !mag_ge && ((cnt != 4'd0) || started || (k == '0));

  assign num_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // clear wins over any handshake presented in the same cycle.
  assign num_acc   = num_valid && num_ready && !clear;
  assign pay_hs    = payload_valid && payload_ready && !clear;
  assign pay_final = pay_hs && payload_last;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (num_valid) state_nxt = num_data[DATA_WIDTH-1] ? S_SIGN : S_DIV;
      S_SIGN: if (payload_ready) state_nxt = S_DIV;
      S_DIV:  if (emit_now) state_nxt = S_EMIT;
      S_EMIT: begin
        if (payload_ready) begin
          if (k != '0) state_nxt = S_DIV;
`ifdef ASCII_FMT_CRLF_EN
          else if (last_f) state_nxt = S_CR;
`endif
          else state_nxt = S_SEP;
        end
      end
`ifdef ASCII_FMT_CRLF_EN
      S_CR:   if (payload_ready) state_nxt = S_SEP;
`endif
      S_SEP:  if (payload_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (clear) state_nxt = S_IDLE;
  end

  // Character decode from registered state only.
  always_comb begin
    payload_valid = 1'b0;
    payload_data  = 8'h00;
    payload_last  = 1'b0;
    case (state)
      S_SIGN: begin
        payload_valid = 1'b1;
        payload_data  = 8'h2D;
      end
      S_EMIT: begin
        payload_valid = 1'b1;
        payload_data  = 8'h30 + {4'h0, cnt};
      end
`ifdef ASCII_FMT_CRLF_EN
      S_CR: begin
        payload_valid = 1'b1;
        payload_data  = 8'h0D;
      end
`endif
      S_SEP: begin
        payload_valid = 1'b1;
        payload_data  = last_f ? 8'h0A : 8'h20;
        payload_last  = last_f;
      end
      default: begin
        payload_valid = 1'b0;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_f     <= 1'b0;
      started    <= 1'b0;
      byte_cnt   <= 16'd0;
      frame_len  <= 16'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= pay_final;

      if (num_acc) begin
        last_f  <= num_last;
        started <= 1'b0;
      end else if ((state == S_DIV) && emit_now) begin
        started <= 1'b1;
      end

      if (clear) begin
        byte_cnt <= 16'd0;
      end else if (pay_final) begin
        frame_len <= byte_cnt + 16'd1;
        byte_cnt  <= 16'd0;
      end else if (pay_hs && (byte_cnt != 16'hFFFF)) begin
        byte_cnt <= byte_cnt + 16'd1;
      end
    end
  end

  // Digit datapath
  always_ff @(posedge clk) begin
    if (num_acc) begin
      mag <= magnitude(num_data);
      k   <= K_TOP;
      cnt <= 4'd0;
    end else if (state == S_DIV) begin
      if (mag_ge) begin
        mag <= mag - pow_k;
        cnt <= cnt + 4'd1;
      end else if (!emit_now) begin
        k   <= k - K_W'(1);
        cnt <= 4'd0;
      end
    end else if ((state == S_EMIT) && payload_ready && (k != '0)) begin
      k   <= k - K_W'(1);
      cnt <= 4'd0;
    end
  end

endmodule

// File: tb/tb_ascii_num_formatter.sv
// Testbench for ascii_num_formatter (DATA_WIDTH = 32). Expected byte streams
// come from a reference model that prints each number with $sformatf and
// appends the separator or the frame terminator.
module tb_ascii_num_formatter;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clear;
  logic signed [31:0] num_data;
  logic               num_valid;
  logic               num_last;
  logic               num_ready;
  logic [7:0]         payload_data;
  logic               payload_valid;
  logic               payload_last;
  logic               payload_ready;
  logic               busy;
  logic               frame_done;
  logic [15:0]        frame_len;

  ascii_num_formatter #(.DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .num_data      (num_data),
    .num_valid     (num_valid),
    .num_last      (num_last),
    .num_ready     (num_ready),
    .payload_data  (payload_data),
    .payload_valid (payload_valid),
    .payload_last  (payload_last),
    .payload_ready (payload_ready),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_len     (frame_len)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit rnd_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Random downstream backpressure, about 30% ready.
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) payload_ready = ($urandom_range(0, 99) < 30);
  end

  // Observed stream and protocol watchers
  logic [7:0]  got_q[$];
  bit          got_last[$];
  int          got_cyc[$];
  int          fd_cnt = 0;
  logic [15:0] fd_len = 16'd0;
  int          hold_viol = 0;
  int          busy_viol = 0;
  bit          p_stall = 1'b0;
  logic [7:0]  p_data = 8'h00;
  logic        p_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall && (payload_valid !== 1'b1 || payload_data !== p_data ||
                      payload_last !== p_last))
        hold_viol++;
      if (num_ready === busy) busy_viol++;
      if (payload_valid && payload_ready && !clear) begin
        got_q.push_back(payload_data);
        got_last.push_back(payload_last);
        got_cyc.push_back(cyc);
      end
      if (frame_done) begin
        fd_cnt++;
        fd_len = frame_len;
      end
      p_stall = payload_valid && !payload_ready && !clear;
      p_data  = payload_data;
      p_last  = payload_last;
    end
  end

  // Reference model
  logic [7:0] exp_q[$];
  int         mdl_cur = 0;
  int         mdl_flen = 0;

  function automatic void model_num(input int v, input bit last);
    string s;
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    mdl_cur += s.len();
    if (last) begin
`ifdef ASCII_FMT_CRLF_EN
      exp_q.push_back(8'h0D);
      mdl_cur++;
`endif
      exp_q.push_back(8'h0A);
      mdl_flen = mdl_cur + 1;
      mdl_cur = 0;
    end else begin
      exp_q.push_back(8'h20);
      mdl_cur++;
    end
  endfunction

  task automatic flush_queues();
    got_q.delete();
    got_last.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  // Present one number and hold it until accepted; returns at posedge+1.
  task automatic push_num(input int v, input bit last);
    int t;
    t = 0;
    num_data  = v;
    num_last  = last;
    num_valid = 1'b1;
    @(negedge clk);
    while (!num_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      n_cmp++; n_fail++;
      $display("FAIL push_timeout: num_ready=%0b after %0d cycles, required 1", num_ready, t);
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    num_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: busy=%0b, required 0", busy);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; num_valid = 1'b0; num_last = 1'b0;
    num_data = 32'sd0; payload_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (num_ready !== 1'b1) begin n_fail++; $display("FAIL rst_num_ready: got %0b, required 1", num_ready); end
    n_cmp++; if (payload_valid !== 1'b0) begin n_fail++; $display("FAIL rst_payload_valid: got %0b, required 0", payload_valid); end
    n_cmp++; if (payload_data !== 8'h00) begin n_fail++; $display("FAIL rst_payload_data: got %h, required 00", payload_data); end
    n_cmp++; if (payload_last !== 1'b0) begin n_fail++; $display("FAIL rst_payload_last: got %0b, required 0", payload_last); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b, required 0", busy); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %0b, required 0", frame_done); end
    n_cmp++; if (frame_len !== 16'd0) begin n_fail++; $display("FAIL rst_frame_len: got %0d, required 0", frame_len); end
    @(posedge clk);
    #1;
  endtask

  // Value 5 with ready tied high: digit at accept+16, space at +17, idle at +18.
  task automatic test_latency();
    int t;
    flush_queues();
    payload_ready = 1'b1;
    push_num(5, 1'b0);
    t = 0;
    while (!num_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++; if (cyc - acc_cyc !== 18) begin n_fail++; $display("FAIL lat_ready: idle after %0d cycles, required 18", cyc - acc_cyc); end
    n_cmp++;
    if (got_q.size() !== 2) begin
      n_fail++; $display("FAIL lat_count: got %0d bytes, required 2", got_q.size());
    end else begin
      n_cmp++; if (got_q[0] !== 8'h35 || got_cyc[0] - acc_cyc !== 16) begin n_fail++; $display("FAIL lat_digit: got %h at +%0d, required 35 at +16", got_q[0], got_cyc[0] - acc_cyc); end
      n_cmp++; if (got_q[1] !== 8'h20 || got_cyc[1] - acc_cyc !== 17) begin n_fail++; $display("FAIL lat_sep: got %h at +%0d, required 20 at +17", got_q[1], got_cyc[1] - acc_cyc); end
    end
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    mdl_cur = 0;
  endtask

  task automatic test_directed();
    int vals[5];
    bit lasts[5];
    int fd0;
    vals  = '{123, -45, 0, 1000000000, 32'sh80000000};
    lasts = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    payload_ready = 1'b1;
    flush_queues();
    fd0 = fd_cnt;
    for (int i = 0; i < 5; i++) begin
      model_num(vals[i], lasts[i]);
      push_num(vals[i], lasts[i]);
      if (lasts[i]) begin
        wait_idle();
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL dir_len[%0d]: got %0d bytes, required %0d", i, got_q.size(), exp_q.size()); end
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
          n_cmp++; if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL dir_byte[%0d][%0d]: got %h, required %h", i, j, got_q[j], exp_q[j]); end
          n_cmp++; if (got_last[j] !== (exp_q[j] == 8'h0A)) begin n_fail++; $display("FAIL dir_last[%0d][%0d]: got %0b, required %0b", i, j, got_last[j], exp_q[j] == 8'h0A); end
        end
        n_cmp++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL dir_frame_done[%0d]: got %0d pulses, required 1", i, fd_cnt - fd0); end
        n_cmp++; if (fd_len !== 16'(mdl_flen)) begin n_fail++; $display("FAIL dir_frame_len[%0d]: got %0d, required %0d", i, fd_len, mdl_flen); end
        flush_queues();
        fd0 = fd_cnt;
      end
    end
  endtask

  task automatic test_random();
    int fd0, n_last, v;
    bit last;
    int specials[7];
    specials = '{0, -1, 32'sh7fffffff, 32'sh80000000, 9, 10, -10};
    flush_queues();
    fd0 = fd_cnt;
    n_last = 0;
    rnd_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom);
        1:       v = int'($urandom_range(0, 20)) - 10;
        2:       v = -int'($urandom_range(0, 99999));
        default: v = specials[$urandom_range(0, 6)];
      endcase
      last = ($urandom_range(0, 3) == 0) || (i == 49);
      if (last) n_last++;
      model_num(v, last);
      push_num(v, last);
    end
    wait_idle();
    rnd_ready = 1'b0;
    payload_ready = 1'b1;
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd_len: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      n_cmp++; if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL rnd_byte[%0d]: got %h, required %h", j, got_q[j], exp_q[j]); end
      n_cmp++; if (got_last[j] !== (exp_q[j] == 8'h0A)) begin n_fail++; $display("FAIL rnd_last[%0d]: got %0b, required %0b", j, got_last[j], exp_q[j] == 8'h0A); end
    end
    n_cmp++; if (fd_cnt - fd0 !== n_last) begin n_fail++; $display("FAIL rnd_frame_done: got %0d pulses, required %0d", fd_cnt - fd0, n_last); end
    n_cmp++; if (fd_len !== 16'(mdl_flen)) begin n_fail++; $display("FAIL rnd_frame_len: got %0d, required %0d", fd_len, mdl_flen); end
    n_cmp++; if (hold_viol !== 0) begin n_fail++; $display("FAIL rnd_hold: got %0d unstable stalls, required 0", hold_viol); end
    n_cmp++; if (busy_viol !== 0) begin n_fail++; $display("FAIL rnd_ready_busy: got %0d overlaps, required 0", busy_viol); end
  endtask

  task automatic test_clear();
    int t, fd0;
    logic [15:0] flen0;
    flush_queues();
    payload_ready = 1'b1;
    push_num(9876, 1'b0);
    t = 0;
    while (!(payload_valid && payload_data == 8'h39) && t < 200) begin @(negedge clk); t++; end
    @(posedge clk); #1 payload_ready = 1'b0;
    t = 0;
    @(negedge clk);
    while (!(payload_valid && payload_data == 8'h38) && t < 200) begin @(negedge clk); t++; end
    n_cmp++; if (t >= 200) begin n_fail++; $display("FAIL clr_reach_digit2: payload_data=%h, required 38", payload_data); end
    fd0 = fd_cnt;
    flen0 = frame_len;
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    n_cmp++; if (payload_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %0b, required 0", payload_valid); end
    n_cmp++; if (num_ready !== 1'b1) begin n_fail++; $display("FAIL clr_num_ready: got %0b, required 1", num_ready); end
    repeat (3) @(negedge clk);
    n_cmp++; if (fd_cnt !== fd0) begin n_fail++; $display("FAIL clr_frame_done: got %0d pulses, required 0", fd_cnt - fd0); end
    n_cmp++; if (frame_len !== flen0) begin n_fail++; $display("FAIL clr_frame_len_hold: got %0d, required %0d", frame_len, flen0); end
    @(posedge clk); #1 payload_ready = 1'b1;
    mdl_cur = 0;
    flush_queues();
    model_num(7, 1'b1);
    push_num(7, 1'b1);
    wait_idle();
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL clr_next_len: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      n_cmp++; if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL clr_next_byte[%0d]: got %h, required %h", j, got_q[j], exp_q[j]); end
    end
    n_cmp++; if (fd_len !== 16'(mdl_flen)) begin n_fail++; $display("FAIL clr_next_frame_len: got %0d, required %0d", fd_len, mdl_flen); end
  endtask

`ifdef ASCII_FMT_CRLF_EN
  task automatic test_crlf();
    logic [7:0] want[4];
    want = '{8'h34, 8'h32, 8'h0D, 8'h0A};
    flush_queues();
    payload_ready = 1'b1;
    push_num(42, 1'b1);
    wait_idle();
    n_cmp++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL crlf_len: got %0d bytes, required 4", got_q.size()); end
    for (int j = 0; j < 4 && j < got_q.size(); j++) begin
      n_cmp++; if (got_q[j] !== want[j]) begin n_fail++; $display("FAIL crlf_byte[%0d]: got %h, required %h", j, got_q[j], want[j]); end
      n_cmp++; if (got_last[j] !== (j == 3)) begin n_fail++; $display("FAIL crlf_last[%0d]: got %0b, required %0b", j, got_last[j], j == 3); end
    end
    n_cmp++; if (fd_len !== 16'd4) begin n_fail++; $display("FAIL crlf_frame_len: got %0d, required 4", fd_len); end
  endtask
`endif

  task automatic test_async_reset();
    int t;
    flush_queues();
    payload_ready = 1'b1;
    push_num(9876, 1'b1);
    t = 0;
    @(negedge clk);
    while (!payload_valid && t < 200) begin @(negedge clk); t++; end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (num_ready !== 1'b1) begin n_fail++; $display("FAIL arst_num_ready: got %0b, required 1", num_ready); end
    n_cmp++; if (payload_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b, required 0", payload_valid); end
    n_cmp++; if (payload_data !== 8'h00) begin n_fail++; $display("FAIL arst_data: got %h, required 00", payload_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %0b, required 0", busy); end
    n_cmp++; if (frame_len !== 16'd0) begin n_fail++; $display("FAIL arst_frame_len: got %0d, required 0", frame_len); end
    @(posedge clk); #1 rst_n = 1'b1;
    mdl_cur = 0;
    flush_queues();
    model_num(-7, 1'b1);
    push_num(-7, 1'b1);
    wait_idle();
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL arst_next_len: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      n_cmp++; if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL arst_next_byte[%0d]: got %h, required %h", j, got_q[j], exp_q[j]); end
    end
    n_cmp++; if (fd_len !== 16'(mdl_flen)) begin n_fail++; $display("FAIL arst_next_frame_len: got %0d, required %0d", fd_len, mdl_flen); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_random();
    test_clear();
`ifdef ASCII_FMT_CRLF_EN
    test_crlf();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
